// File: rtl/qspi_port_arbiter.sv
// ============================================================================
// qspi_port_arbiter
// ----------------------------------------------------------------------------
// Shares one QSPI flash/PSRAM master between the CPU instruction-fetch port
// and the load/store data port. Sequential instruction fetches keep the
// master paused with chip select low (STREAM) and are resumed with m_cont,
// so command and address are not re-sent. A data access, or a fetch that
// breaks the sequence, closes the stream with m_stop and restarts from IDLE.
//
// Optional feature (compile-time macro QSPI_ARB_STREAM_TIMEOUT_EN):
//   when defined, an idle STREAM is closed after STREAM_TIMEOUT cycles with
//   no request. When undefined, STREAM is held indefinitely and no counter
//   exists.
//
// Parameters:
//   STREAM_TIMEOUT  idle cycles in STREAM before m_stop (macro only)
//   TO_W            timeout counter width, STREAM_TIMEOUT < 2**TO_W
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ready), byte address
//   if_ready/if_data    one-cycle fetch completion pulse and instruction
//   d_req/d_we/d_addr   data request (held until d_ready), direction, address
//   d_len/d_wdata       data length in bits (0 = no access), write data
//   d_ready/d_rdata     one-cycle data completion pulse and read data
//   m_start/m_stop/m_cont  one-cycle master sequencing pulses
//   m_we/m_is_instr/m_addr/m_len/m_wdata  master operation, loaded with
//                       m_start and held until the next m_start
//   m_rdata/m_done      master read data and completion
// All outputs are registered and reset to 0.
// ============================================================================
module qspi_port_arbiter #(
  parameter int STREAM_TIMEOUT = 64,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [23:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [23:0] d_addr,
  input  logic [5:0]  d_len,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,

  output logic        m_start,
  output logic        m_stop,
  output logic        m_cont,
  output logic        m_we,
  output logic        m_is_instr,
  output logic [23:0] m_addr,
  output logic [5:0]  m_len,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_STREAM = 3'd2,
    ST_STOP   = 3'd3,
    ST_DATA   = 3'd4
  } state_t;

  // An instruction fetch always asks the master for a full 32-bit word; a
  // compressed instruction simply uses the upper halfword.
  localparam logic [5:0] FETCH_LEN = 6'd32;

  if (STREAM_TIMEOUT < 1 || STREAM_TIMEOUT >= (2 ** TO_W)) begin : g_bad_timeout
    $error("qspi_port_arbiter: STREAM_TIMEOUT must be in 1 .. 2**TO_W-1");
  end

  // Size of the instruction just fetched. m_rdata is in flash byte order,
  // so the first byte at the fetch address lands in [31:24]; its two LSBs
  // (m_rdata[25:24]) are the RISC-V length bits: 2'b11 means 32-bit.
  function automatic logic [23:0] instr_step(input logic [31:0] rdata);
    instr_step = (rdata[25:24] != 2'b11) ? 24'd2 : 24'd4;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [23:0] fetch_addr;
  logic [23:0] fetch_addr_nxt;
  logic [23:0] next_addr;
  logic [23:0] next_addr_nxt;

  logic        if_ready_nxt;
  logic [31:0] if_data_nxt;
  logic        d_ready_nxt;
  logic [31:0] d_rdata_nxt;
  logic        m_start_nxt;
  logic        m_stop_nxt;
  logic        m_cont_nxt;
  logic        m_we_nxt;
  logic        m_is_instr_nxt;
  logic [23:0] m_addr_nxt;
  logic [5:0]  m_len_nxt;
  logic [31:0] m_wdata_nxt;

  logic [23:0] if_addr_hw;
  logic        unused_if_addr_lsb;
  logic        d_req_v;
  logic        if_req_v;
  logic        to_expire;

  // Fetches are halfword aligned; the byte-select bit is dropped.
  assign if_addr_hw         = {if_addr[23:1], 1'b0};
  assign unused_if_addr_lsb = if_addr[0];

  // A requester keeps its request high during the cycle its ready pulse is
  // out; only a request still high after that is a new one.
  assign d_req_v  = d_req  & ~d_ready;
  assign if_req_v = if_req & ~if_ready;

`ifdef QSPI_ARB_STREAM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Counts idle STREAM cycles; any other state, or a request, clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ST_STREAM && !d_req_v && !if_req_v) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_expire = (to_cnt == TO_W'(STREAM_TIMEOUT - 1));
`else
  assign to_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    next_addr_nxt  = next_addr;
    if_ready_nxt   = 1'b0;
    if_data_nxt    = if_data;
    d_ready_nxt    = 1'b0;
    d_rdata_nxt    = d_rdata;
    m_start_nxt    = 1'b0;
    m_stop_nxt     = 1'b0;
    m_cont_nxt     = 1'b0;
    m_we_nxt       = m_we;
    m_is_instr_nxt = m_is_instr;
    m_addr_nxt     = m_addr;
    m_len_nxt      = m_len;
    m_wdata_nxt    = m_wdata;

    unique case (state)
      ST_IDLE: begin
        if (d_req_v) begin
          if (d_len != 6'd0) begin
            m_start_nxt    = 1'b1;
            m_we_nxt       = d_we;
            m_is_instr_nxt = 1'b0;
            m_addr_nxt     = d_addr;
            m_len_nxt      = d_len;
            m_wdata_nxt    = d_wdata;
            state_nxt      = ST_DATA;
          end else begin
            // Zero-length access completes locally without the master.
            d_ready_nxt = 1'b1;
            d_rdata_nxt = 32'h0;
          end
        end else if (if_req_v) begin
          m_start_nxt    = 1'b1;
          m_we_nxt       = 1'b0;
          m_is_instr_nxt = 1'b1;
          m_addr_nxt     = if_addr_hw;
          m_len_nxt      = FETCH_LEN;
          m_wdata_nxt    = 32'h0;
          fetch_addr_nxt = if_addr_hw;
          state_nxt      = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (m_done) begin
          if_ready_nxt  = 1'b1;
          if_data_nxt   = m_rdata;
          next_addr_nxt = fetch_addr + instr_step(m_rdata);
          state_nxt     = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (d_req_v) begin
          m_stop_nxt = 1'b1;
          state_nxt  = ST_STOP;
        end else if (if_req_v) begin
          if (if_addr_hw == next_addr) begin
            // Sequential: resume the paused transfer; m_addr keeps the
            // address of the original command.
            m_cont_nxt     = 1'b1;
            fetch_addr_nxt = next_addr;
            state_nxt      = ST_FETCH;
          end else begin
            m_stop_nxt = 1'b1;
            state_nxt  = ST_STOP;
          end
        end else if (to_expire) begin
          m_stop_nxt = 1'b1;
          state_nxt  = ST_STOP;
        end
      end

      ST_STOP: begin
        state_nxt = ST_IDLE;
      end

      ST_DATA: begin
        if (m_done) begin
          d_ready_nxt = 1'b1;
          d_rdata_nxt = m_we ? 32'h0 : m_rdata;
          state_nxt   = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs and address tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr <= 24'h0;
      next_addr  <= 24'h0;
      if_ready   <= 1'b0;
      if_data    <= 32'h0;
      d_ready    <= 1'b0;
      d_rdata    <= 32'h0;
      m_start    <= 1'b0;
      m_stop     <= 1'b0;
      m_cont     <= 1'b0;
      m_we       <= 1'b0;
      m_is_instr <= 1'b0;
      m_addr     <= 24'h0;
      m_len      <= 6'h0;
      m_wdata    <= 32'h0;
    end else begin
      fetch_addr <= fetch_addr_nxt;
      next_addr  <= next_addr_nxt;
      if_ready   <= if_ready_nxt;
      if_data    <= if_data_nxt;
      d_ready    <= d_ready_nxt;
      d_rdata    <= d_rdata_nxt;
      m_start    <= m_start_nxt;
      m_stop     <= m_stop_nxt;
      m_cont     <= m_cont_nxt;
      m_we       <= m_we_nxt;
      m_is_instr <= m_is_instr_nxt;
      m_addr     <= m_addr_nxt;
      m_len      <= m_len_nxt;
      m_wdata    <= m_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_qspi_port_arbiter.sv
// ============================================================================
// tb_qspi_port_arbiter
// ----------------------------------------------------------------------------
// Directed bench for qspi_port_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge. The
// QSPI master is played by the bench (m_done/m_rdata). Fetch data is given
// in flash byte order: 0x9300A000 is "addi x1,x0,10" (0x00A00093, 32-bit)
// and 0x45010000 holds the compressed halfword 0x0145.
// ============================================================================
module tb_qspi_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [23:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_we;
  logic [23:0] d_addr;
  logic [5:0]  d_len;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_start;
  logic        m_stop;
  logic        m_cont;
  logic        m_we;
  logic        m_is_instr;
  logic [23:0] m_addr;
  logic [5:0]  m_len;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_done;

  int vec  = 0;
  int errs = 0;

  wire [132:0] outs = {if_ready, if_data, d_ready, d_rdata, m_start, m_stop,
                       m_cont, m_we, m_is_instr, m_addr, m_len, m_wdata};

  always #5 clk = ~clk;

  qspi_port_arbiter #(
    .STREAM_TIMEOUT(4),
    .TO_W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_data   (if_data),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_len     (d_len),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .m_start   (m_start),
    .m_stop    (m_stop),
    .m_cont    (m_cont),
    .m_we      (m_we),
    .m_is_instr(m_is_instr),
    .m_addr    (m_addr),
    .m_len     (m_len),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_done    (m_done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Master finishes the current fetch/data transfer; returns in the cycle
  // where the ready pulse is visible.
  task automatic master_done(input logic [31:0] data);
    m_rdata = data;
    m_done  = 1'b1;
    tick();
    m_done  = 1'b0;
    m_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = 24'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 24'h0; d_len = 6'd0; d_wdata = 32'h0; m_rdata = 32'h0; m_done = 1'b0;
    tick(); tick();
    vec++;
    if (outs !== 133'h0) begin
      errs++; $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    rst = 1'b0;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont, if_ready, d_ready} !== 5'b0) begin
      errs++; $display("FAIL idle_quiet: got %b, expected 00000",
                       {m_start, m_stop, m_cont, if_ready, d_ready});
    end
  endtask

  task automatic test_first_fetch();
    if_req = 1'b1; if_addr = 24'h000100;
    tick();
    vec++;
    if ({m_start, m_is_instr, m_we, m_addr} !== {1'b1, 1'b1, 1'b0, 24'h000100}) begin
      errs++; $display("FAIL fetch_start: got start=%b instr=%b we=%b addr=%h, expected 1 1 0 000100",
                       m_start, m_is_instr, m_we, m_addr);
    end
    tick();
    vec++;
    if (m_start !== 1'b0) begin
      errs++; $display("FAIL start_pulse_width: got %b, expected 0", m_start);
    end
    master_done(32'h9300A000);
    vec++;
    if ({if_ready, if_data} !== {1'b1, 32'h9300A000}) begin
      errs++; $display("FAIL fetch_ready: got %b %h, expected 1 9300a000", if_ready, if_data);
    end
    tick();
    vec++;
    if ({if_ready, m_start, m_stop, m_cont} !== 4'b0) begin
      errs++; $display("FAIL held_req_ignored: got %b, expected 0000",
                       {if_ready, m_start, m_stop, m_cont});
    end
  endtask

  task automatic test_stream();
    if_addr = 24'h000104;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b001) begin
      errs++; $display("FAIL cont_104: got %b, expected 001", {m_start, m_stop, m_cont});
    end
    vec++;
    if (m_addr !== 24'h000100) begin
      errs++; $display("FAIL m_addr_held: got %h, expected 000100", m_addr);
    end
    master_done(32'h45010000);
    vec++;
    if ({if_ready, if_data} !== {1'b1, 32'h45010000}) begin
      errs++; $display("FAIL compressed_ready: got %b %h, expected 1 45010000", if_ready, if_data);
    end
    tick();
    if_addr = 24'h000106;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b001) begin
      errs++; $display("FAIL cont_106: got %b, expected 001", {m_start, m_stop, m_cont});
    end
    master_done(32'h9300A000);
    tick();
    if_addr = 24'h00010A;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b001) begin
      errs++; $display("FAIL cont_10a: got %b, expected 001", {m_start, m_stop, m_cont});
    end
    master_done(32'h45010000);
    tick();
    if_req = 1'b0;
    // A stray m_done in STREAM must not produce a fetch completion.
    m_done = 1'b1; m_rdata = 32'hFFFFFFFF;
    tick();
    m_done = 1'b0; m_rdata = 32'h0;
    vec++;
    if ({if_ready, if_data} !== {1'b0, 32'h45010000}) begin
      errs++; $display("FAIL done_in_stream: got %b %h, expected 0 45010000", if_ready, if_data);
    end
  endtask

  task automatic test_nonseq();
    if_req = 1'b1; if_addr = 24'h000201;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b010) begin
      errs++; $display("FAIL nonseq_stop: got %b, expected 010", {m_start, m_stop, m_cont});
    end
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b000) begin
      errs++; $display("FAIL nonseq_gap: got %b, expected 000", {m_start, m_stop, m_cont});
    end
    tick();
    vec++;
    if ({m_start, m_is_instr, m_addr} !== {1'b1, 1'b1, 24'h000200}) begin
      errs++; $display("FAIL nonseq_restart: got start=%b instr=%b addr=%h, expected 1 1 000200",
                       m_start, m_is_instr, m_addr);
    end
    master_done(32'h45010000);
    tick();
    if_req = 1'b0;
  endtask

  task automatic test_data_preempt();
    d_req = 1'b1; d_we = 1'b1; d_addr = 24'h001000; d_len = 6'd32; d_wdata = 32'hDEADBEEF;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b010) begin
      errs++; $display("FAIL preempt_stop: got %b, expected 010", {m_start, m_stop, m_cont});
    end
    tick(); tick();
    vec++;
    if ({m_start, m_we, m_is_instr, m_addr, m_len, m_wdata} !==
        {1'b1, 1'b1, 1'b0, 24'h001000, 6'd32, 32'hDEADBEEF}) begin
      errs++; $display("FAIL write_start: got %b%b%b %h %0d %h, expected 110 001000 32 deadbeef",
                       m_start, m_we, m_is_instr, m_addr, m_len, m_wdata);
    end
    master_done(32'h12345678);
    vec++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h0}) begin
      errs++; $display("FAIL write_ready: got %b %h, expected 1 00000000", d_ready, d_rdata);
    end
    tick();
    vec++;
    if ({d_ready, m_start} !== 2'b00) begin
      errs++; $display("FAIL write_no_repeat: got %b, expected 00", {d_ready, m_start});
    end
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_simultaneous();
    d_req = 1'b1; d_we = 1'b0; d_addr = 24'h002000; d_len = 6'd8;
    if_req = 1'b1; if_addr = 24'h000300;
    tick();
    vec++;
    if ({m_start, m_is_instr, m_we, m_addr, m_len} !== {3'b100, 24'h002000, 6'd8}) begin
      errs++; $display("FAIL data_wins: got %b%b%b %h %0d, expected 100 002000 8",
                       m_start, m_is_instr, m_we, m_addr, m_len);
    end
    master_done(32'hA5000000);
    vec++;
    if ({d_ready, d_rdata, if_ready} !== {1'b1, 32'hA5000000, 1'b0}) begin
      errs++; $display("FAIL read_ready: got %b %h %b, expected 1 a5000000 0", d_ready, d_rdata, if_ready);
    end
    tick();
    d_req = 1'b0;
    vec++;
    if ({m_start, m_is_instr, m_addr} !== {1'b1, 1'b1, 24'h000300}) begin
      errs++; $display("FAIL fetch_after_data: got %b%b %h, expected 11 000300",
                       m_start, m_is_instr, m_addr);
    end
    master_done(32'h9300A000);
    vec++;
    if ({if_ready, if_data} !== {1'b1, 32'h9300A000}) begin
      errs++; $display("FAIL fetch_after_data_ready: got %b %h, expected 1 9300a000", if_ready, if_data);
    end
    tick();
    if_req = 1'b0;
  endtask

  task automatic test_zero_len();
    d_req = 1'b1; d_we = 1'b0; d_addr = 24'h003000; d_len = 6'd0;
    tick();
    vec++;
    if (m_stop !== 1'b1) begin
      errs++; $display("FAIL zlen_stop: got %b, expected 1", m_stop);
    end
    tick();
    vec++;
    if (d_ready !== 1'b0) begin
      errs++; $display("FAIL zlen_early: got %b, expected 0", d_ready);
    end
    tick();
    vec++;
    if ({d_ready, d_rdata, m_start} !== {1'b1, 32'h0, 1'b0}) begin
      errs++; $display("FAIL zlen_ready: got %b %h start=%b, expected 1 00000000 0", d_ready, d_rdata, m_start);
    end
    tick();
    vec++;
    if ({d_ready, m_start} !== 2'b00) begin
      errs++; $display("FAIL zlen_once: got %b, expected 00", {d_ready, m_start});
    end
    d_req = 1'b0;
  endtask

  task automatic test_stream_idle();
    logic seen;
    if_req = 1'b1; if_addr = 24'h000400;
    tick();
    vec++;
    if (m_start !== 1'b1) begin
      errs++; $display("FAIL idle_fetch_start: got %b, expected 1", m_start);
    end
    master_done(32'h9300A000);
    if_req = 1'b0;
`ifdef QSPI_ARB_STREAM_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | m_stop;
    end
    vec++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL timeout_early: got %b, expected 0", seen);
    end
    tick();
    vec++;
    if ({m_stop, m_start, m_cont} !== 3'b100) begin
      errs++; $display("FAIL timeout_stop: got %b, expected 100", {m_stop, m_start, m_cont});
    end
    tick();
    if_req = 1'b1; if_addr = 24'h000404;
    tick();
    vec++;
    if ({m_start, m_cont, m_addr} !== {2'b10, 24'h000404}) begin
      errs++; $display("FAIL timeout_restart: got %b %h, expected 10 000404", {m_start, m_cont}, m_addr);
    end
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen = seen | m_stop | m_start | m_cont;
    end
    vec++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL stream_hold: got %b, expected 0", seen);
    end
    if_req = 1'b1; if_addr = 24'h000404;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b001) begin
      errs++; $display("FAIL stream_hold_cont: got %b, expected 001", {m_start, m_stop, m_cont});
    end
`endif
    master_done(32'h45010000);
    tick();
    if_req = 1'b0;
  endtask

  task automatic test_wrap();
    if_req = 1'b1; if_addr = 24'hFFFFFE;
    tick(); tick(); tick();
    vec++;
    if ({m_start, m_addr} !== {1'b1, 24'hFFFFFE}) begin
      errs++; $display("FAIL wrap_start: got %b %h, expected 1 fffffe", m_start, m_addr);
    end
    master_done(32'h45010000);
    tick();
    if_addr = 24'h000000;
    tick();
    vec++;
    if ({m_start, m_stop, m_cont} !== 3'b001) begin
      errs++; $display("FAIL wrap_cont: got %b, expected 001", {m_start, m_stop, m_cont});
    end
    master_done(32'h9300A000);
    tick();
    if_req = 1'b0;
  endtask

  task automatic test_rst_mid();
    if_req = 1'b1; if_addr = 24'h000500;
    tick(); tick(); tick();
    vec++;
    if ({m_start, m_addr} !== {1'b1, 24'h000500}) begin
      errs++; $display("FAIL rst_setup: got %b %h, expected 1 000500", m_start, m_addr);
    end
    tick();
    rst = 1'b1;
    #1;
    vec++;
    if (outs !== 133'h0) begin
      errs++; $display("FAIL rst_async: got %h, expected 0", outs);
    end
    tick();
    rst = 1'b0;
    tick();
    vec++;
    if ({m_start, m_is_instr, m_addr} !== {2'b11, 24'h000500}) begin
      errs++; $display("FAIL rst_idle: got %b%b %h, expected 11 000500", m_start, m_is_instr, m_addr);
    end
    master_done(32'h9300A000);
    tick();
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_stream();
    test_nonseq();
    test_data_preempt();
    test_simultaneous();
    test_zero_len();
    test_stream_idle();
    test_wrap();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
